// File: rtl/mdu_iter.sv
// mdu_iter: iterative RISC-V M-extension multiply/divide unit.
// Ports: i_clk/i_rst_n clock and async low reset; i_flush aborts the
// current op; i_valid/o_ready request handshake with i_op (funct3),
// i_w32 (W-form, XLEN=64 only), i_src1/i_src2; o_valid/i_ready result
// handshake with o_dest held stable until accepted.
module mdu_iter #(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic            i_w32,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_dest
);
    localparam int CW = $clog2(XLEN / STEP_BITS + 1);
    localparam int PW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nx;

    // low 32 bits, sign- or zero-extended to XLEN
    function automatic logic [XLEN-1:0] ext32(
        input logic [XLEN-1:0] x,
        input logic            sg
    );
        logic [XLEN-1:0] r;
        r       = {XLEN{sg & x[31]}};
        r[31:0] = x[31:0];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] pick(
        input logic [2:0]      op,
        input logic            w,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic [PW-1:0]   p
    );
        logic [XLEN-1:0] v;
        if (op[2])
            v = op[1] ? r : q;
        else if (op[1:0] == 2'd0)
            v = p[XLEN-1:0];
        else
            v = p[PW-1:XLEN];
        return w ? ext32(v, 1'b1) : v;
    endfunction

    // request decode
    logic            accept, in_div, in_w, sg1, sg2;
    logic            neg1, neg2, dz, ovf, hit, fast;
    logic [XLEN-1:0] a_ext, b_ext, mag1, mag2, mn;
    logic [XLEN-1:0] fq, fr, fast_res;

    // operation registers
    logic [2:0]      op_q;
    logic            w_q, sg_q, n1_q, n2_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc, mc;
    logic [XLEN-1:0] mp, rem, quo, dvs;
    logic [XLEN-1:0] dest;

    // reuse cache
    logic            c_vld, c_sg, c_w;
    logic [XLEN-1:0] c_a, c_b, c_q, c_r;

    // per-cycle datapath
    logic [PW-1:0]   acc_n, mc_n, prod_f;
    logic [XLEN-1:0] mp_n, rem_n, quo_n, quo_f, rem_f, calc_res;
    logic [XLEN:0]   tr;

    always_comb begin
        in_div = i_op[2];
        in_w   = (XLEN == 64) && i_w32 && (i_op[2] || i_op == 3'd0);
        sg1    = i_op[2] ? ~i_op[0] : (i_op != 3'd3);
        sg2    = i_op[2] ? ~i_op[0] : ~i_op[1];
        a_ext  = in_w ? ext32(i_src1, sg1) : i_src1;
        b_ext  = in_w ? ext32(i_src2, sg2) : i_src2;
        neg1   = sg1 & a_ext[XLEN-1];
        neg2   = sg2 & b_ext[XLEN-1];
        mag1   = neg1 ? -a_ext : a_ext;
        mag2   = neg2 ? -b_ext : b_ext;
        // most negative value of the effective width, extended
        if (in_w) begin
            mn       = '1;
            mn[31:0] = 32'h8000_0000;
        end else begin
            mn         = '0;
            mn[XLEN-1] = 1'b1;
        end
        dz   = in_div && b_ext == '0;
        ovf  = in_div && sg1 && a_ext == mn && b_ext == '1;
        hit  = in_div && c_vld && c_a == a_ext && c_b == b_ext
               && c_sg == sg1 && c_w == in_w;
        fast = dz | ovf | hit;
        fq   = c_q;
        fr   = c_r;
        unique case (1'b1)
            dz: begin
                fq = '1;
                fr = a_ext;
            end
            ovf: begin
                fq = a_ext;
                fr = '0;
            end
            default: begin
                fq = c_q;
                fr = c_r;
            end
        endcase
        fast_res = pick(i_op, in_w, fq, fr, '0);
    end

    always_comb begin
        acc_n = acc;
        mc_n  = mc;
        mp_n  = mp;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (mp_n[0])
                acc_n = acc_n + mc_n;
            mc_n = mc_n << 1;
            mp_n = mp_n >> 1;
        end
        tr    = '0;
        rem_n = rem;
        quo_n = quo;
        for (int i = 0; i < STEP_BITS; i++) begin
            tr    = {rem_n, quo_n[XLEN-1]};
            quo_n = quo_n << 1;
            if (tr >= {1'b0, dvs}) begin
                tr       = tr - {1'b0, dvs};
                quo_n[0] = 1'b1;
            end
            rem_n = tr[XLEN-1:0];
        end
        prod_f   = (n1_q ^ n2_q) ? -acc_n : acc_n;
        quo_f    = (n1_q ^ n2_q) ? -quo_n : quo_n;
        rem_f    = n1_q ? -rem_n : rem_n;
        calc_res = pick(op_q, w_q, quo_f, rem_f, prod_f);
    end

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = fast ? DONE : CALC;
            CALC: if (cnt == CW'(1)) state_nx = DONE;
            DONE: if (i_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (i_flush)
            state_nx = IDLE;
    end

    // outputs
    always_comb begin
        o_ready = (state == IDLE) && !i_flush;
        o_valid = (state == DONE);
        accept  = i_valid && o_ready;
        o_dest  = dest;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q  <= '0;
            w_q   <= 1'b0;
            sg_q  <= 1'b0;
            n1_q  <= 1'b0;
            n2_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            acc   <= '0;
            mc    <= '0;
            mp    <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            dest  <= '0;
            c_vld <= 1'b0;
            c_sg  <= 1'b0;
            c_w   <= 1'b0;
            c_a   <= '0;
            c_b   <= '0;
            c_q   <= '0;
            c_r   <= '0;
        end else if (accept) begin
            op_q <= i_op;
            w_q  <= in_w;
            sg_q <= sg1;
            n1_q <= neg1;
            n2_q <= neg2;
            a_q  <= a_ext;
            b_q  <= b_ext;
            acc  <= '0;
            mc   <= PW'(mag1);
            mp   <= mag2;
            rem  <= '0;
            // W divides start with the 32-bit dividend at the top
            quo  <= in_w ? (mag1 << (XLEN - 32)) : mag1;
            dvs  <= mag2;
            if (fast) begin
                cnt  <= '0;
                dest <= fast_res;
            end else begin
                cnt <= in_w ? CW'(32 / STEP_BITS)
                            : CW'(XLEN / STEP_BITS);
            end
        end else if (state == CALC) begin
            if (i_flush) begin
                cnt <= '0;
            end else begin
                cnt <= cnt - 1'b1;
                acc <= acc_n;
                mc  <= mc_n;
                mp  <= mp_n;
                rem <= rem_n;
                quo <= quo_n;
                if (cnt == CW'(1)) begin
                    dest <= calc_res;
                    if (op_q[2]) begin
                        c_vld <= 1'b1;
                        c_a   <= a_q;
                        c_b   <= b_q;
                        c_sg  <= sg_q;
                        c_w   <= w_q;
                        c_q   <= quo_f;
                        c_r   <= rem_f;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed bench for mdu_iter at XLEN=32/STEP=1 and
// XLEN=64/STEP=2, checked against an arithmetic reference model.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        fl_a = 0, val_a = 0, rdy_a, w_a = 0, ov_a, ir_a = 0;
    logic [2:0]  op_a = 0;
    logic [31:0] s1_a = 0, s2_a = 0, dest_a, exp_a = 0;

    logic        fl_b = 0, val_b = 0, rdy_b, w_b = 0, ov_b, ir_b = 0;
    logic [2:0]  op_b = 0;
    logic [63:0] s1_b = 0, s2_b = 0, dest_b, exp_b = 0;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(32), .STEP_BITS(1)) u32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(fl_a),
        .i_valid(val_a), .o_ready(rdy_a), .i_op(op_a),
        .i_w32(w_a), .i_src1(s1_a), .i_src2(s2_a),
        .o_valid(ov_a), .i_ready(ir_a), .o_dest(dest_a)
    );

    mdu_iter #(.XLEN(64), .STEP_BITS(2)) u64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(fl_b),
        .i_valid(val_b), .o_ready(rdy_b), .i_op(op_b),
        .i_w32(w_b), .i_src1(s1_b), .i_src2(s2_b),
        .o_valid(ov_b), .i_ready(ir_b), .o_dest(dest_b)
    );

    function automatic logic signed [127:0] sx(
        input logic [63:0] v, input int wd);
        if (wd == 32) return {{96{v[31]}}, v[31:0]};
        return {{64{v[63]}}, v};
    endfunction

    function automatic logic signed [127:0] zx(
        input logic [63:0] v, input int wd);
        if (wd == 32) return {96'b0, v[31:0]};
        return {64'b0, v};
    endfunction

    // reference: exact integer arithmetic, then truncation
    function automatic logic [63:0] model(
        input int xl, input logic [2:0] op, input logic w,
        input logic [63:0] a, input logic [63:0] b);
        bit ww;
        int wd;
        logic signed [127:0] sa, sb, ua, ub, r;
        logic [63:0] o;
        ww = (xl == 64) && w && (op == 3'd0 || op[2]);
        wd = ww ? 32 : xl;
        sa = sx(a, wd);
        sb = sx(b, wd);
        ua = zx(a, wd);
        ub = zx(b, wd);
        case (op)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> xl;
            3'd2: r = (sa * ub) >>> xl;
            3'd3: r = (ua * ub) >>> xl;
            3'd4: r = (sb == 0) ? -1 : sa / sb;
            3'd5: r = (ub == 0) ? -1 : ua / ub;
            3'd6: r = (sb == 0) ? sa : sa % sb;
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        o = '0;
        if (ww) o = {{32{r[31]}}, r[31:0]};
        else if (xl == 32) o[31:0] = r[31:0];
        else o = r[63:0];
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, want);
    endtask

    function automatic logic ov(input bit big);
        return big ? ov_b : ov_a;
    endfunction

    function automatic logic rdy(input bit big);
        return big ? rdy_b : rdy_a;
    endfunction

    function automatic logic [63:0] dst(input bit big);
        return big ? dest_b : {32'b0, dest_a};
    endfunction

    // every cycle with a valid result: o_dest must equal the model
    always @(negedge clk) begin
        if (rst_n && ov_a) chk("dest32", {32'b0, dest_a}, {32'b0, exp_a});
        if (rst_n && ov_b) chk("dest64", dest_b, exp_b);
    end

    task automatic start(input bit big, input logic [2:0] op,
        input logic w, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m;
        @(negedge clk);
        chk("ready before accept", rdy(big), 1);
        m = model(big ? 64 : 32, op, w, a, b);
        if (big) begin
            op_b = op; w_b = w; s1_b = a; s2_b = b;
            exp_b = m; val_b = 1;
        end else begin
            op_a = op; w_a = w; s1_a = a[31:0]; s2_a = b[31:0];
            exp_a = m[31:0]; val_a = 1;
        end
        @(posedge clk);
        #1;
        val_a = 0;
        val_b = 0;
    endtask

    task automatic finish(input bit big, input string nm,
        input int lat, input bit uselit, input logic [63:0] lit,
        input int hold);
        int n;
        n = 1;
        while (!ov(big) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, " latency"}, n, lat);
        if (uselit) chk({nm, " literal"}, dst(big), lit);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({nm, " hold valid"}, ov(big), 1);
            chk({nm, " hold ready"}, rdy(big), 0);
        end
        @(negedge clk);
        if (big) ir_b = 1; else ir_a = 1;
        @(posedge clk);
        #1;
        ir_a = 0;
        ir_b = 0;
        #1;
        chk({nm, " valid drop"}, ov(big), 0);
        chk({nm, " ready back"}, rdy(big), 1);
    endtask

    task automatic op1(input bit big, input string nm,
        input logic [2:0] op, input logic w, input logic [63:0] a,
        input logic [63:0] b, input int lat, input bit uselit,
        input logic [63:0] lit);
        start(big, op, w, a, b);
        finish(big, nm, lat, uselit, lit, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst ready32", rdy_a, 1);
        chk("rst valid32", ov_a, 0);
        chk("rst dest32", dest_a, 0);
        chk("rst ready64", rdy_b, 1);
        chk("rst valid64", ov_b, 0);
        chk("rst dest64", dest_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // XLEN=32, one bit per cycle
        op1(0, "mul", 0, 0, 7, 32'hFFFF_FFFD, 33, 1, 64'hFFFF_FFEB);
        op1(0, "mulh", 1, 0, 7, 32'hFFFF_FFFD, 33, 1, 64'hFFFF_FFFF);
        op1(0, "mulhu", 3, 0, 7, 32'hFFFF_FFFD, 33, 1, 64'h6);
        op1(0, "mulhsu", 2, 0, 32'hFFFF_FFFD, 7, 33, 1, 64'hFFFF_FFFF);
        op1(0, "mulh min", 1, 0, 32'h8000_0000, 32'h8000_0000,
            33, 1, 64'h4000_0000);
        op1(0, "div ovf", 4, 0, 32'h8000_0000, 32'hFFFF_FFFF,
            1, 1, 64'h8000_0000);
        op1(0, "rem ovf", 6, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 0);
        op1(0, "divu z", 5, 0, 5, 0, 1, 1, 64'hFFFF_FFFF);
        op1(0, "remu z", 7, 0, 5, 0, 1, 1, 5);
        op1(0, "div -7/2", 4, 0, 32'hFFFF_FFF9, 2, 33, 1, 64'hFFFF_FFFD);
        op1(0, "rem hit", 6, 0, 32'hFFFF_FFF9, 2, 1, 1, 64'hFFFF_FFFF);
        start(0, 6, 0, 32'hFFFF_FFF9, 3);
        finish(0, "rem -7/3 bp", 33, 1, 64'hFFFF_FFFF, 10);
        op1(0, "divu big", 5, 0, 32'hFFFF_FFFF, 1, 33, 1, 64'hFFFF_FFFF);

        // flush in CALC: no result, no cache write
        start(0, 4, 0, 1000, 7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        fl_a = 1;
        @(posedge clk);
        #1;
        fl_a = 0;
        #1;
        chk("flush ready", rdy_a, 1);
        chk("flush valid", ov_a, 0);
        op1(0, "divu 100/7", 5, 0, 100, 7, 33, 1, 14);
        op1(0, "reissue", 4, 0, 1000, 7, 33, 1, 142);
        op1(0, "rem 1000/7", 6, 0, 1000, 7, 1, 1, 6);

        // flush beats i_ready in DONE
        start(0, 5, 0, 9, 0);
        chk("fz valid", ov_a, 1);
        @(negedge clk);
        fl_a = 1;
        ir_a = 1;
        @(posedge clk);
        #1;
        fl_a = 0;
        ir_a = 0;
        #1;
        chk("fz drop", ov_a, 0);
        chk("fz ready", rdy_a, 1);

        // XLEN=64, two bits per cycle
        op1(1, "divw", 4, 1, 64'hFFFF_FFFF_FFFF_FFF8, 3, 17, 1,
            64'hFFFF_FFFF_FFFF_FFFE);
        op1(1, "remw hit", 6, 1, 64'hFFFF_FFFF_FFFF_FFF8, 3, 1, 1,
            64'hFFFF_FFFF_FFFF_FFFE);
        op1(1, "mul64", 0, 0, 64'h1_0000_0001, 64'hFFFF_FFFF, 33, 1,
            64'hFFFF_FFFF_FFFF_FFFF);
        op1(1, "mulhu64", 3, 0, 64'h1_0000_0001, 64'hFFFF_FFFF, 33, 1, 0);
        op1(1, "mulw", 0, 1, 64'h8000_0000, 2, 17, 1, 0);
        op1(1, "divuw", 5, 1, 64'hFFFF_FFFF_0000_0010, 4, 17, 1, 4);
        op1(1, "divw ovf", 4, 1, 64'h8000_0000, 64'hFFFF_FFFF, 1, 1,
            64'hFFFF_FFFF_8000_0000);
        op1(1, "mulh64", 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7, 33, 0, 0);

        // async reset mid-CALC
        start(1, 5, 0, 1000, 3);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("arst valid", ov_b, 0);
        chk("arst dest", dest_b, 0);
        chk("arst ready", rdy_b, 1);
        @(negedge clk);
        rst_n = 1;
        op1(1, "remw no cache", 6, 1, 64'hFFFF_FFFF_FFFF_FFF8, 3, 17, 1,
            64'hFFFF_FFFF_FFFF_FFFE);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit for the execute stage, the successor to the fixed-width mul_div_unit. It implements the RISC-V M-extension ops (plus W-forms when XLEN=64) with a configurable number of result bits per cycle. It takes operands over a valid/ready handshake and holds the result until the consumer accepts it. Fast paths resolve divide-by-zero, signed overflow and the DIV→REM reuse pair in one cycle.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- STEP_BITS, 1: quotient/multiplier bits retired per CALC cycle; 1, 2 or 4; must divide 32.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous assertion, active-low; one clock, no other clock domains.
- i_flush  in  1  abort the in-flight op; highest priority.
- i_valid  in  1  request valid.
- o_ready  out  1  unit idle, can accept.
- i_op  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_w32  in  1  W-form; honoured only when XLEN=64 and op ∈ {MUL, DIV, DIVU, REM, REMU}; otherwise ignored.
- i_src1 / i_src2  in  XLEN  operands.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_dest  out  XLEN  result.

## Operation
- States: IDLE, CALC, DONE.
- o_ready = (state==IDLE) & ~i_flush.
- **IDLE**
  - Accept on i_valid & o_ready: latch op, w32 and operands.
  - W-form operands: low 32 bits, sign-extended (signed ops) or zero-extended (unsigned ops).
  - Fast path to DONE when any of these holds:
    - divisor==0: quotient all-ones; remainder = dividend.
    - Signed overflow, dividend=min_int(width) and divisor=-1: quotient = dividend; remainder 0.
    - Reuse hit (see below).
  - Otherwise go to CALC with counter N = (w32 ? 32 : XLEN)/STEP_BITS.
- **CALC**
  - Multiply: shift-add on operand magnitudes, STEP_BITS bits per cycle.
  - Divide: restoring division on magnitudes, STEP_BITS quotient bits per cycle.
  - Counter decrements each cycle; at 1, go to DONE and apply sign fix-up:
    - Quotient sign = s1^s2.
    - Remainder sign = sign of dividend.
    - MULH* use sign per operand signedness.
- **Result selection**
  - MUL: low XLEN bits of the product.
  - MULH*: high XLEN bits of the product.
  - W-form results: low 32 bits sign-extended to 64.
- **DONE**
  - o_valid=1; o_dest stable.
  - On i_ready, go to IDLE.
  - The next request cannot be accepted in the same cycle; o_ready is low in DONE.
- **Reuse cache**
  - Every completed non-fast divide stores {src1, src2, signedness, w32, quotient, remainder}.
  - A new divide/rem with identical src1, src2, signedness and w32 hits the cache and takes the 1-cycle path, regardless of whether DIV or REM was first.
  - Cache invalidated only by reset; flush does not invalidate it.
  - A flushed op does not write the cache.
- **i_flush**, any state: next edge goes to IDLE, o_valid=0; i_valid is ignored that cycle.

## Timing
- **Reset** (async): state IDLE, o_ready=1, o_valid=0, o_dest=0, cache invalid, counter 0.
- **Latency**, counted from the acceptance edge:
  - Iterative: o_valid high after N+1 edges (XLEN=32, STEP_BITS=1: 33 edges).
  - Fast path: o_valid high after 1 edge.
- **Back-pressure:** o_valid and o_dest are held unchanged while i_ready=0, for any number of cycles.
- **Throughput:** at most one op per N+2 cycles (iterative), or one per 2 cycles (fast), since IDLE is needed for acceptance.
- **Flush and i_ready in the same cycle in DONE:** flush wins; result dropped.
- **Reset mid-CALC:** all outputs return to reset values immediately.
- o_dest does not change outside the CALC→DONE or IDLE→DONE transition.

## Test plan
- XLEN=32, STEP_BITS=1, MUL src1=7, src2=0xFFFFFFFD → o_valid at edge 33, o_dest=0xFFFFFFEB; MULH same operands → 0xFFFFFFFF; MULHU → 0x00000006.
- DIV 0x80000000 / 0xFFFFFFFF → o_valid after 1 edge, o_dest=0x80000000; REM same → 0; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- DIV -7/2 (iterative) → 0xFFFFFFFD at edge 33; then REM -7/2 → 0xFFFFFFFF after 1 edge (cache hit); REM -7/3 → iterative 33 edges, 0xFFFFFFFF.
- Hold i_ready=0 for 10 cycles in DONE → o_valid, o_dest constant, o_ready=0; i_ready=1 → IDLE next edge, o_ready=1.
- Assert i_flush at CALC cycle 10 → o_valid never rises, o_ready=1 next edge; immediate new DIVU 100/7 → 14 at edge 33; reissue of the flushed operands takes the full latency (no cache write).
- XLEN=64, STEP_BITS=2, DIVW src1=0xFFFFFFFF_FFFFFFF8 (-8), src2=3 → 16 CALC cycles, o_dest=0xFFFFFFFF_FFFFFFFE; async reset mid-CALC → o_valid=0, o_dest=0 without a clock edge.
